// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer.
// Contents: pipState encodings, trace FSM encodings, entry field-width helpers.
package pipe_trace_pkg;

    // Per-stage pipeline state as reported on stage_state.
    typedef enum logic [1:0] {
        PIP_IDLE      = 2'b00,
        PIP_WAIT_BEF  = 2'b01,
        PIP_SENDING   = 2'b10,
        PIP_WAIT_SEND = 2'b11
    } pip_state_e;

    // Trace controller state as reported on fsm_state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_POST    = 2'b10,
        ST_DRAIN   = 2'b11
    } trace_fsm_e;

    // Width of the packed stage_state field.
    function automatic int unsigned state_bits_w(int unsigned num_stages);
        return 2 * num_stages;
    endfunction

    // Width of one trace entry: {cycle stamp, stage_state, stage_fire}.
    function automatic int unsigned entry_w(int unsigned cyc_w, int unsigned num_stages);
        return cyc_w + 3 * num_stages;
    endfunction

endpackage

// File: rtl/pipe_trace_buf_if.sv
// Read-out handshake bundle of the trace buffer.
//   rd_valid : entry on rd_data is valid (producer -> consumer)
//   rd_ready : consumer accepts the entry   (consumer -> producer)
//   rd_data  : {cycle stamp, stage_state, stage_fire}, stamp in MSBs
// Modports: master = trace buffer side, slave = consumer side.
interface pipe_trace_buf_if #(
    parameter int W = 44
) ();
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pipe_trace_ram.sv
// Simple dual-port trace RAM, DEPTH x W, registered read port.
//   clk      : clock
//   rst      : async active-high reset (clears the read register only)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, captured into rdata_o at the clock edge
//   rdata_o  : registered read data
// A same-edge write to the read address is forwarded so the read register
// never holds stale data for the location just written.
module pipe_trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pipe_trace_buf.sv
// Pipeline trace buffer: records per-cycle pipeline stage state/fire with a
// free-running cycle stamp into a circular RAM, stops a programmable number of
// entries after a trigger, then drains oldest-first over a valid/ready port.
//   clk, rst     : clock, async active-high reset
//   arm          : start capture (IDLE only)
//   trig         : trigger, starts post-trigger countdown (CAPTURE only)
//   stage_state  : 2 bits per stage, stage 0 in LSBs
//   stage_fire   : 1 bit per stage
//   rd           : read-out handshake (master modport)
//   fsm_state    : 00 IDLE, 01 CAPTURE, 10 POST, 11 DRAIN
//   count        : entries held
//   overflow     : sticky, an entry was overwritten or dropped
// Optional feature: define TRACE_CHANGE_ONLY_EN to record only cycles whose
// stage_state changed since the last written entry or that have any fire.
module pipe_trace_buf
    import pipe_trace_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int DEPTH      = 64,
    parameter int CYC_W      = 32,
    parameter int WRAP       = 1,
    parameter int POST_TRIG  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  arm,
    input  logic                                  trig,
    input  logic [state_bits_w(NUM_STAGES)-1:0]   stage_state,
    input  logic [NUM_STAGES-1:0]                 stage_fire,
    pipe_trace_buf_if.master                      rd,
    output logic [1:0]                            fsm_state,
    output logic [$clog2(DEPTH):0]                count,
    output logic                                  overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(CYC_W, NUM_STAGES);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
    localparam logic [CW-1:0] POST_N = CW'(POST_TRIG);

    trace_fsm_e       fsm_q, fsm_d;
    logic [CYC_W-1:0] cyc_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    post_q, post_d;
    logic             ovf_q, ovf_d;

    logic             qual;
    logic             is_full;
    logic             we;
    logic             wrote;
    logic             rd_valid;
    logic             xfer;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;

`ifdef TRACE_CHANGE_ONLY_EN
    logic [state_bits_w(NUM_STAGES)-1:0] last_q, last_d;
    logic                                first_q, first_d;
    assign qual = first_q | (stage_state != last_q) | (|stage_fire);
`else
    assign qual = 1'b1;
`endif

    assign is_full  = (count_q == FULL_N);
    assign rd_valid = (fsm_q == ST_DRAIN) && (count_q != '0);
    assign xfer     = rd_valid & rd.rd_ready;
    assign wdata    = {cyc_q, stage_state, stage_fire};

    always_comb begin
        fsm_d    = fsm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        wrote    = 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
        last_d   = last_q;
        first_d  = first_q;
`endif
        case (fsm_q)
            ST_IDLE: begin
                if (arm) begin
                    fsm_d    = ST_CAPTURE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    post_d   = '0;
                    ovf_d    = 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
                    first_d  = 1'b1;
`endif
                end
            end
            ST_CAPTURE, ST_POST: begin
                if (qual) begin
                    if (!is_full) begin
                        we       = 1'b1;
                        wrote    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                    end else if (WRAP != 0) begin
                        // Overwrite oldest: both pointers advance, count stays at DEPTH.
                        we       = 1'b1;
                        wrote    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        ovf_d    = 1'b1;
                    end else begin
                        ovf_d    = 1'b1;
                    end
                end
`ifdef TRACE_CHANGE_ONLY_EN
                if (wrote) begin
                    last_d  = stage_state;
                    first_d = 1'b0;
                end
`endif
                // The trigger cycle's own write counts toward POST_TRIG.
                if (fsm_q == ST_CAPTURE) begin
                    if (trig) begin
                        post_d = CW'(wrote);
                        fsm_d  = (wrote && (POST_N == CW'(1))) ? ST_DRAIN : ST_POST;
                    end
                end else begin
                    post_d = post_q + CW'(wrote);
                    if (wrote && (post_q + CW'(1) == POST_N)) begin
                        fsm_d = ST_DRAIN;
                    end
                end
                if (qual && is_full && (WRAP == 0)) begin
                    fsm_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    fsm_d = ST_IDLE;
                end else if (xfer) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        fsm_d = ST_IDLE;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            cyc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
            last_q   <= '0;
            first_q  <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            cyc_q    <= cyc_q + CYC_W'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            ovf_q    <= ovf_d;
`ifdef TRACE_CHANGE_ONLY_EN
            last_q   <= last_d;
            first_q  <= first_d;
`endif
        end
    end

    // Reading at the next-state pointer keeps the registered read data aligned
    // with the oldest entry in the same cycle the pointer register updates.
    pipe_trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (rdata)
    );

    assign rd.rd_valid = rd_valid;
    assign rd.rd_data  = rdata;
    assign fsm_state   = fsm_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_pipe_trace_buf.sv
// Directed self-checking bench for pipe_trace_buf.
// Three instances: default params (d), DEPTH=8 WRAP=1 POST_TRIG=4 (w),
// DEPTH=8 WRAP=0 POST_TRIG=4 (n). All share stimulus; each test resets first.
module tb_pipe_trace_buf;
    localparam int EW = 32 + 3 * 4;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       trig;
    logic [7:0] stage_state;
    logic [3:0] stage_fire;
    logic       rd_ready;

    logic [1:0] fsm_d, fsm_w, fsm_n;
    logic [6:0] cnt_d;
    logic [3:0] cnt_w, cnt_n;
    logic       ovf_d, ovf_w, ovf_n;

    logic [31:0] tb_cyc;
    int total;
    int bad;

    pipe_trace_buf_if #(.W(EW)) if_d ();
    pipe_trace_buf_if #(.W(EW)) if_w ();
    pipe_trace_buf_if #(.W(EW)) if_n ();

    assign if_d.rd_ready = rd_ready;
    assign if_w.rd_ready = rd_ready;
    assign if_n.rd_ready = rd_ready;

    pipe_trace_buf dut_d (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig),
        .stage_state(stage_state), .stage_fire(stage_fire), .rd(if_d),
        .fsm_state(fsm_d), .count(cnt_d), .overflow(ovf_d)
    );

    pipe_trace_buf #(.DEPTH(8), .WRAP(1), .POST_TRIG(4)) dut_w (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig),
        .stage_state(stage_state), .stage_fire(stage_fire), .rd(if_w),
        .fsm_state(fsm_w), .count(cnt_w), .overflow(ovf_w)
    );

    pipe_trace_buf #(.DEPTH(8), .WRAP(0), .POST_TRIG(4)) dut_n (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig),
        .stage_state(stage_state), .stage_fire(stage_fire), .rd(if_n),
        .fsm_state(fsm_n), .count(cnt_n), .overflow(ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: the value the DUT stamps into an entry.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
        stage_state = '0; stage_fire = '0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic arm_now();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fsm_w !== 2'b00) begin bad++; $display("FAIL reset_fsm: got %0d want 0", fsm_w); end
        total++; if (cnt_w !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt_w); end
        total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0d want 0", ovf_w); end
        total++; if (if_w.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d want 0", if_w.rd_valid); end
        total++; if (if_w.rd_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", if_w.rd_data); end
    endtask

    task automatic test_capture();
        do_reset();
        arm_now();
        stage_fire = 4'h1;
        for (int i = 0; i < 10; i++) begin
            stage_state = 8'(i * 3);
            tick();
        end
        total++; if (cnt_d !== 7'd10) begin bad++; $display("FAIL cap_count: got %0d want 10", cnt_d); end
        total++; if (fsm_d !== 2'b01) begin bad++; $display("FAIL cap_fsm: got %0d want 1", fsm_d); end
        total++; if (ovf_d !== 1'b0) begin bad++; $display("FAIL cap_ovf: got %0d want 0", ovf_d); end
        total++; if (if_d.rd_valid !== 1'b0) begin bad++; $display("FAIL cap_valid: got %0d want 0", if_d.rd_valid); end
    endtask

    task automatic test_trig_rules();
        do_reset();
        trig = 1'b1;
        tick();
        total++; if (fsm_w !== 2'b00) begin bad++; $display("FAIL trig_idle: got %0d want 0", fsm_w); end
        arm = 1'b1;
        tick();
        arm = 1'b0; trig = 1'b0;
        total++; if (fsm_w !== 2'b01) begin bad++; $display("FAIL arm_trig: got %0d want 1", fsm_w); end
        total++; if (cnt_w !== 4'd0) begin bad++; $display("FAIL arm_nowrite: got %0d want 0", cnt_w); end
    endtask

    task automatic test_wrap();
        logic [EW-1:0] q[$];
        logic [EW-1:0] exp;
        do_reset();
        arm_now();
        for (int i = 0; i < 24; i++) begin
            if (i == 20) trig = 1'b1;
            stage_state = 8'(i * 37);
            stage_fire  = 4'(i);
            q.push_back({tb_cyc, stage_state, stage_fire});
            if (q.size() > 8) void'(q.pop_front());
            tick();
            trig = 1'b0;
            if (i == 19) begin
                total++; if (fsm_w !== 2'b01) begin bad++; $display("FAIL wrap_capture: got %0d want 1", fsm_w); end
                total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_ovf_early: got %0d want 1", ovf_w); end
            end
            if (i == 22) begin
                total++; if (fsm_w !== 2'b10) begin bad++; $display("FAIL wrap_post: got %0d want 2", fsm_w); end
            end
        end
        total++; if (fsm_w !== 2'b11) begin bad++; $display("FAIL wrap_drain: got %0d want 3", fsm_w); end
        total++; if (cnt_w !== 4'd8) begin bad++; $display("FAIL wrap_count: got %0d want 8", cnt_w); end
        total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_ovf: got %0d want 1", ovf_w); end
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = q.pop_front();
            total++; if (if_w.rd_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d]: got %0d want 1", k, if_w.rd_valid); end
            total++; if (if_w.rd_data !== exp) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", k, if_w.rd_data, exp); end
            tick();
        end
        rd_ready = 1'b0;
        total++; if (fsm_w !== 2'b00) begin bad++; $display("FAIL wrap_idle: got %0d want 0", fsm_w); end
        total++; if (cnt_w !== 4'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", cnt_w); end
        total++; if (if_w.rd_valid !== 1'b0) begin bad++; $display("FAIL wrap_valid_end: got %0d want 0", if_w.rd_valid); end
    endtask

    task automatic test_nowrap_stall();
        logic [EW-1:0] q[$];
        logic [EW-1:0] prev;
        logic          stalled;
        int            nread;
        do_reset();
        arm_now();
        for (int i = 0; i < 12; i++) begin
            stage_state = 8'(i * 11 + 5);
            stage_fire  = 4'(15 - i);
            if (i < 8) q.push_back({tb_cyc, stage_state, stage_fire});
            tick();
            if (i == 7) begin
                total++; if (fsm_n !== 2'b01) begin bad++; $display("FAIL nowrap_capture: got %0d want 1", fsm_n); end
                total++; if (ovf_n !== 1'b0) begin bad++; $display("FAIL nowrap_ovf_early: got %0d want 0", ovf_n); end
            end
            if (i == 8) begin
                total++; if (fsm_n !== 2'b11) begin bad++; $display("FAIL nowrap_drain: got %0d want 3", fsm_n); end
            end
        end
        total++; if (cnt_n !== 4'd8) begin bad++; $display("FAIL nowrap_count: got %0d want 8", cnt_n); end
        total++; if (ovf_n !== 1'b1) begin bad++; $display("FAIL nowrap_ovf: got %0d want 1", ovf_n); end
        nread = 0;
        stalled = 1'b0;
        prev = '0;
        for (int k = 0; k < 40; k++) begin
            if (fsm_n == 2'b00) break;
            rd_ready = (k % 2 == 0);
            if (if_n.rd_valid) begin
                if (stalled) begin
                    total++; if (if_n.rd_data !== prev) begin bad++; $display("FAIL stall_hold[%0d]: got %h want %h", k, if_n.rd_data, prev); end
                end
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL stall_extra[%0d]: got %h want none", k, if_n.rd_data);
                end else if (if_n.rd_data !== q[0]) begin
                    bad++; $display("FAIL stall_data[%0d]: got %h want %h", k, if_n.rd_data, q[0]);
                end
                if (rd_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    nread++;
                end
                prev = if_n.rd_data;
                stalled = !rd_ready;
            end
            tick();
        end
        rd_ready = 1'b0;
        total++; if (nread !== 8) begin bad++; $display("FAIL stall_nread: got %0d want 8", nread); end
        total++; if (fsm_n !== 2'b00) begin bad++; $display("FAIL stall_idle: got %0d want 0", fsm_n); end
    endtask

    task automatic test_rst_drain();
        do_reset();
        arm_now();
        stage_fire = 4'h2;
        repeat (9) tick();
        rd_ready = 1'b1;
        repeat (3) tick();
        total++; if (cnt_n !== 4'd5) begin bad++; $display("FAIL rstd_pre_count: got %0d want 5", cnt_n); end
        #3 rst = 1'b1;
        #1;
        total++; if (fsm_n !== 2'b00) begin bad++; $display("FAIL rstd_fsm: got %0d want 0", fsm_n); end
        total++; if (cnt_n !== 4'd0) begin bad++; $display("FAIL rstd_count: got %0d want 0", cnt_n); end
        total++; if (if_n.rd_valid !== 1'b0) begin bad++; $display("FAIL rstd_valid: got %0d want 0", if_n.rd_valid); end
        rst = 1'b0;
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_change_only();
        do_reset();
        arm_now();
        stage_state = 8'h00;
        for (int i = 0; i < 50; i++) begin
            stage_fire = (i == 20) ? 4'h1 : 4'h0;
            tick();
        end
`ifdef TRACE_CHANGE_ONLY_EN
        total++; if (cnt_d !== 7'd2) begin bad++; $display("FAIL chg_count: got %0d want 2", cnt_d); end
`else
        total++; if (cnt_d !== 7'd50) begin bad++; $display("FAIL chg_count: got %0d want 50", cnt_d); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
        stage_state = '0; stage_fire = '0;
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_capture();
        test_trig_rules();
        test_wrap();
        test_nowrap_stall();
        test_rst_drain();
        test_change_only();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
